// File: rtl/util_edge_event_arbiter.sv
// util_edge_event_arbiter
// Per-input two-flop synchronizer, debounce and edge capture into a one-deep
// pending slot per input. Slots drain through a round-robin arbiter onto a
// single valid/ready event port. A sticky overflow flag records dropped edges.
module util_edge_event_arbiter #(
  parameter int N               = 16,
  parameter int IDX_W           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [N-1:0]     in,
  input  logic [N-1:0]     rise_en,
  input  logic [N-1:0]     fall_en,
  output logic [N-1:0]     level,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_idx,
  output logic             ev_rise,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [15:0] DEB_LIM = 16'(DEBOUNCE_CYCLES);

  logic [N-1:0]     s1_r, s2_r, level_r, pend_r, pend_pol_r;
  logic [15:0]      cnt_r     [N];
  logic [15:0]      cnt_nxt_s [N];
  logic [N-1:0]     level_nxt_s, new_ev_s, drop_s, grant_oh_s;
  logic [N-1:0]     pend_nxt_s, pol_nxt_s, req_hi_s;
  logic             grant_vld_s, grant_pol_s, free_s, take_s, ovf_nxt_s;
  logic [IDX_W-1:0] grant_idx_s, ptr_r, ptr_nxt_s;
  logic             ev_valid_r, ev_rise_r, overflow_r;
  logic [IDX_W-1:0] ev_idx_r;

  assign level    = level_r;
  assign ev_valid = ev_valid_r;
  assign ev_idx   = ev_idx_r;
  assign ev_rise  = ev_rise_r;
  assign overflow = overflow_r;

  // Debounce: count consecutive disagreement cycles, flip the level at the limit.
  always_comb begin
    level_nxt_s = level_r;
    for (int i = 0; i < N; i++) begin
      cnt_nxt_s[i] = 16'd0;
      if (s2_r[i] == level_r[i]) begin
        cnt_nxt_s[i] = 16'd0;
      end else if ((cnt_r[i] + 16'd1) == DEB_LIM) begin
        level_nxt_s[i] = s2_r[i];
        cnt_nxt_s[i]   = 16'd0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + 16'd1;
      end
    end
  end

  // Round-robin grant: lowest pending index at or above the pointer, else lowest overall.
  always_comb begin
    req_hi_s = '0;
    for (int i = 0; i < N; i++) begin
      req_hi_s[i] = pend_r[i] && (i >= int'(ptr_r));
    end
    grant_vld_s = |pend_r;
    grant_idx_s = '0;
    grant_pol_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((|req_hi_s) ? req_hi_s[i] : pend_r[i]) begin
        grant_idx_s = IDX_W'(i);
        grant_pol_s = pend_pol_r[i];
      end else begin
        grant_idx_s = grant_idx_s;
        grant_pol_s = grant_pol_s;
      end
    end
    free_s    = !ev_valid_r || ev_ready;
    take_s    = free_s && grant_vld_s;
    ptr_nxt_s = (grant_idx_s == IDX_W'(N - 1)) ? '0 : (grant_idx_s + IDX_W'(1));
    grant_oh_s = '0;
    for (int i = 0; i < N; i++) begin
      grant_oh_s[i] = take_s && (grant_idx_s == IDX_W'(i));
    end
  end

  // Edge capture into pending slots; a full slot keeps its event unless granted this cycle.
  always_comb begin
    pend_nxt_s = pend_r;
    pol_nxt_s  = pend_pol_r;
    new_ev_s   = '0;
    drop_s     = '0;
    for (int i = 0; i < N; i++) begin
      new_ev_s[i] = (level_nxt_s[i] != level_r[i]) &&
                    (level_nxt_s[i] ? rise_en[i] : fall_en[i]);
      if (new_ev_s[i]) begin
        if (pend_r[i] && !grant_oh_s[i]) begin
          drop_s[i] = 1'b1;
        end else begin
          pend_nxt_s[i] = 1'b1;
          pol_nxt_s[i]  = level_nxt_s[i];
        end
      end else if (grant_oh_s[i]) begin
        pend_nxt_s[i] = 1'b0;
      end else begin
        pend_nxt_s[i] = pend_r[i];
      end
    end
    if (|drop_s) begin
      ovf_nxt_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = overflow_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      s1_r       <= '0;
      s2_r       <= '0;
      level_r    <= '0;
      pend_r     <= '0;
      pend_pol_r <= '0;
      ptr_r      <= '0;
      ev_valid_r <= 1'b0;
      ev_idx_r   <= '0;
      ev_rise_r  <= 1'b0;
      overflow_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= 16'd0;
      end
    end else begin
      s1_r       <= in;
      s2_r       <= s1_r;
      level_r    <= level_nxt_s;
      pend_r     <= pend_nxt_s;
      pend_pol_r <= pol_nxt_s;
      overflow_r <= ovf_nxt_s;
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      if (take_s) begin
        ev_valid_r <= 1'b1;
        ev_idx_r   <= grant_idx_s;
        ev_rise_r  <= grant_pol_s;
        ptr_r      <= ptr_nxt_s;
      end else if (free_s) begin
        ev_valid_r <= 1'b0;
      end else begin
        ev_valid_r <= ev_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_util_edge_event_arbiter.sv
// Bench for util_edge_event_arbiter (N=4, DEBOUNCE_CYCLES=4): directed
// scenarios followed by random stimulus, all compared every cycle against a
// behavioural model of the event path.
module tb_util_edge_event_arbiter;

  localparam int N = 4;
  localparam int IW = 2;
  localparam int D = 4;

  logic          clk;
  logic          res;
  logic [N-1:0]  din, rise_en, fall_en, level;
  logic          ev_valid, ev_ready, ev_rise, overflow, ovf_clr;
  logic [IW-1:0] ev_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [N-1:0]  m_s1, m_s2, m_level, m_pend, m_pol;
  int            m_run [N];
  logic          m_valid, m_rise, m_ovf;
  logic [IW-1:0] m_idx;
  int            m_ptr;

  util_edge_event_arbiter #(.N(N), .IDX_W(IW), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .res(res), .in(din), .rise_en(rise_en), .fall_en(fall_en),
    .level(level), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx),
    .ev_rise(ev_rise), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance the reference by one clock edge using the inputs currently driven
  task automatic model_step();
    logic [N-1:0] nl;
    int g;
    logic gpol;
    logic drop;
    if (!res) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0; m_pol = '0;
      m_valid = 1'b0; m_idx = '0; m_rise = 1'b0; m_ovf = 1'b0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      return;
    end
    nl = m_level;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= D) begin
          nl[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    g = -1;
    gpol = 1'b0;
    if (!m_valid || ev_ready) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (g >= 0) begin
      gpol = m_pol[g];
      m_pend[g] = 1'b0;
    end
    drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (nl[i] != m_level[i] && (nl[i] ? rise_en[i] : fall_en[i])) begin
        if (m_pend[i]) drop = 1'b1;
        else begin
          m_pend[i] = 1'b1;
          m_pol[i]  = nl[i];
        end
      end
    end
    if (g >= 0) begin
      m_valid = 1'b1;
      m_idx   = IW'(g);
      m_rise  = gpol;
      m_ptr   = (g + 1) % N;
    end else if (!m_valid || ev_ready) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_level = nl;
    m_s2 = m_s1;
    m_s1 = din;
  endtask

  task automatic model_check();
    chk("level",    32'(level),    32'(m_level));
    chk("ev_valid", 32'(ev_valid), 32'(m_valid));
    chk("ev_idx",   32'(ev_idx),   32'(m_idx));
    chk("ev_rise",  32'(ev_rise),  32'(m_rise));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  initial begin
    res = 1'b0; din = '0; rise_en = '1; fall_en = '1; ev_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    res = 1'b1;
    repeat (2) tick();

    // single rising edge on input 2: level after 6 edges, event after 7
    din = 4'b0100;
    repeat (6) tick();
    chk("t1_level", 32'(level), 32'h4);
    chk("t1_valid_early", 32'(ev_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(ev_valid), 32'd1);
    chk("t1_idx", 32'(ev_idx), 32'd2);
    chk("t1_rise", 32'(ev_rise), 32'd1);
    ev_ready = 1'b1;
    tick();
    chk("t1_drain", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;

    // glitch of three cycles on input 1
    din = 4'b0110;
    repeat (3) tick();
    din = 4'b0100;
    repeat (8) tick();
    chk("glitch_level", 32'(level), 32'h4);
    chk("glitch_valid", 32'(ev_valid), 32'd0);
    chk("glitch_ovf", 32'(overflow), 32'd0);

    // round robin: park (1,rise) on the port, then pend 0,1,3 with pointer at 2
    din = 4'b0110;
    repeat (8) tick();
    chk("rr_first", 32'(ev_idx), 32'd1);
    din = 4'b1101;
    repeat (8) tick();
    ev_ready = 1'b1;
    tick();
    chk("rr_a", 32'(ev_idx), 32'd3);
    tick();
    chk("rr_b", 32'(ev_idx), 32'd0);
    tick();
    chk("rr_c", 32'(ev_idx), 32'd1);
    chk("rr_c_pol", 32'(ev_rise), 32'd0);
    tick();
    chk("rr_end", 32'(ev_valid), 32'd0);

    // backpressure and overflow on input 0
    din = 4'b0000;
    repeat (10) tick();
    ev_ready = 1'b0;
    din = 4'b0001;
    repeat (8) tick();
    din = 4'b0000;
    repeat (8) tick();
    din = 4'b0001;
    repeat (8) tick();
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_hold_idx", 32'(ev_idx), 32'd0);
    chk("bp_hold_rise", 32'(ev_rise), 32'd1);
    ev_ready = 1'b1;
    tick();
    chk("bp_second", 32'({ev_valid, ev_idx, ev_rise}), 32'({1'b1, 2'd0, 1'b0}));
    tick();
    chk("bp_empty", 32'(ev_valid), 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("bp_clr", 32'(overflow), 32'd0);

    // rising edges masked on input 3
    rise_en = 4'b0111;
    din = 4'b1001;
    repeat (8) tick();
    chk("mask_level_hi", 32'(level), 32'h9);
    chk("mask_no_rise", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;
    din = 4'b0001;
    repeat (8) tick();
    chk("mask_fall", 32'({ev_valid, ev_idx, ev_rise}), 32'({1'b1, 2'd3, 1'b0}));
    ev_ready = 1'b1;
    tick();
    rise_en = 4'b1111;

    // reset while events are pending and one is on the port
    ev_ready = 1'b0;
    din = 4'b1111;
    repeat (8) tick();
    chk("mid_valid", 32'(ev_valid), 32'd1);
    din = 4'b0000;
    res = 1'b0;
    tick();
    chk("mid_rst", 32'({level, ev_valid, ev_idx, ev_rise, overflow}), 32'd0);
    res = 1'b1;
    repeat (10) tick();
    chk("mid_after", 32'(ev_valid), 32'd0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) din[b] = ~din[b];
      end
      ev_ready = ($urandom_range(0, 2) != 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      if ((c % 64) == 0) begin
        rise_en = N'($urandom);
        fall_en = N'($urandom);
      end
      res = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
